// File: rtl/if_stage_if.sv
// Bundle between the fetch stage, the ID stage and the instruction SRAM.
// The fetch stage uses the master modport; its environment uses slave.
interface if_stage_if;
    logic        ds_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_to_ds_valid;
    logic [64:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    modport master (
        input  ds_allowin,
        input  br_taken,
        input  br_target,
        input  inst_sram_rdata,
        output fs_to_ds_valid,
        output fs_to_ds_bus,
        output inst_sram_en,
        output inst_sram_we,
        output inst_sram_addr,
        output inst_sram_wdata
    );

    modport slave (
        output ds_allowin,
        output br_taken,
        output br_target,
        output inst_sram_rdata,
        input  fs_to_ds_valid,
        input  fs_to_ds_bus,
        input  inst_sram_en,
        input  inst_sram_we,
        input  inst_sram_addr,
        input  inst_sram_wdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction
// SRAM and hands {adef, pc, inst} to ID over a valid/allowin handshake.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic      clk,
    input  logic      reset,
    if_stage_if.master bus
);

    logic        fs_valid_q,       fs_valid_d;
    logic [31:0] fs_pc_q,          fs_pc_d;
    logic        fs_adef_q,        fs_adef_d;
    logic        first_fetch_q,    first_fetch_d;
    logic [31:0] inst_buf_q,       inst_buf_d;
    logic        inst_buf_valid_q, inst_buf_valid_d;

    logic        fs_allowin;
    logic        to_fs_go;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic        nextpc_misaligned;
    logic [31:0] fs_inst;

    assign fs_allowin        = ~fs_valid_q | bus.ds_allowin;
    assign seq_pc            = first_fetch_q ? RESET_PC : fs_pc_q + 32'd4;
    assign nextpc            = bus.br_taken ? bus.br_target : seq_pc;
    assign nextpc_misaligned = |nextpc[1:0];
    // A redirect issues its target fetch even while ID is stalling.
    assign to_fs_go          = ~reset & (fs_allowin | bus.br_taken);

    always_comb begin
        // NOTE: each _d starts at its hold value so every path assigns it and no latch is inferred.
        fs_valid_d       = fs_valid_q;
        fs_pc_d          = fs_pc_q;
        fs_adef_d        = fs_adef_q;
        first_fetch_d    = first_fetch_q;
        inst_buf_d       = inst_buf_q;
        inst_buf_valid_d = inst_buf_valid_q;

        if (to_fs_go) begin
            fs_valid_d    = 1'b1;
            fs_pc_d       = nextpc;
            fs_adef_d     = nextpc_misaligned;
            first_fetch_d = 1'b0;
        end else if (bus.ds_allowin && fs_valid_q) begin
            fs_valid_d = 1'b0;
        end

        // SRAM data is only valid for one cycle; park it while ID stalls.
        if (bus.br_taken || bus.ds_allowin) begin
            inst_buf_valid_d = 1'b0;
        end else if (fs_valid_q && !inst_buf_valid_q) begin
            inst_buf_valid_d = 1'b1;
            inst_buf_d       = bus.inst_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            fs_valid_q       <= 1'b0;
            fs_pc_q          <= RESET_PC - 32'd4;
            fs_adef_q        <= 1'b0;
            first_fetch_q    <= 1'b1;
            inst_buf_valid_q <= 1'b0;
        end else begin
            fs_valid_q       <= fs_valid_d;
            fs_pc_q          <= fs_pc_d;
            fs_adef_q        <= fs_adef_d;
            first_fetch_q    <= first_fetch_d;
            inst_buf_valid_q <= inst_buf_valid_d;
        end
    end

    // NOTE: buffer data needs no reset; it is never used unless inst_buf_valid_q is set.
    always_ff @(posedge clk) begin
        inst_buf_q <= inst_buf_d;
    end

    assign fs_inst = fs_adef_q        ? 32'h0 :
                     inst_buf_valid_q ? inst_buf_q : bus.inst_sram_rdata;

    // The instruction in IF during a redirect is wrong-path and is dropped.
    assign bus.fs_to_ds_valid  = fs_valid_q & ~bus.br_taken & ~reset;
    assign bus.fs_to_ds_bus    = {fs_adef_q, fs_pc_q, fs_inst};
    assign bus.inst_sram_en    = to_fs_go & ~nextpc_misaligned;
    assign bus.inst_sram_we    = 1'b0;
    assign bus.inst_sram_addr  = nextpc;
    assign bus.inst_sram_wdata = 32'h0;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage, directly upstream of the decode/execute datapath. It owns the PC and drives the synchronous instruction SRAM (1-cycle read latency).
- Delivers {excp, pc, inst} to the ID stage through a valid/allowin handshake.
- Accepts branch/jump redirects from ID and cancels the wrong-path fetch.
- A one-entry instruction buffer keeps SRAM read data safe while ID stalls.

Parameters:
- RESET_PC, 32'h1c000000, address of the first fetch after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ds_allowin  in  1  ID can accept an instruction this cycle.
- br_taken  in  1  redirect request from ID; already qualified by ID valid.
- br_target  in  32  redirect address.
- fs_to_ds_valid  out  1  fs_to_ds_bus holds a valid instruction.
- fs_to_ds_bus  out  65  {adef[64], pc[63:32], inst[31:0]}.
- inst_sram_en  out  1  read enable.
- inst_sram_we  out  1  constant 0.
- inst_sram_addr  out  32  fetch address.
- inst_sram_wdata  out  32  constant 0.
- inst_sram_rdata  in  32  data for the address presented in the previous cycle with en=1.

Behaviour:
- State:
  - fs_valid, fs_pc[31:0], fs_adef.
  - inst_buf[31:0], inst_buf_valid.
  - first_fetch flag, which marks the first cycle out of reset.
- Reset (reset=1 at posedge):
  - fs_valid=0, inst_buf_valid=0, fs_adef=0, fs_pc=RESET_PC-4, first_fetch=1.
  - While reset=1: inst_sram_en=0, fs_to_ds_valid=0.
  - Reset wins over every other input.
- Handshake:
  - fs_ready_go=1.
  - fs_allowin = ~fs_valid | ds_allowin.
  - A transfer to ID occurs when fs_to_ds_valid & ds_allowin.
- Next PC (combinational):
  - nextpc = br_taken ? br_target : (first_fetch ? RESET_PC : fs_pc+4).
  - 32-bit add, wraps modulo 2^32.
- Fetch issue:
  - to_fs_go = ~reset & (fs_allowin | br_taken).
  - inst_sram_addr = nextpc.
  - inst_sram_en = to_fs_go & (nextpc[1:0]==2'b00).
- Fetch capture: on posedge with to_fs_go:
  - fs_valid<=1, fs_pc<=nextpc, fs_adef<=(nextpc[1:0]!=0), first_fetch<=0.
  - Otherwise, if ds_allowin & fs_valid: fs_valid<=0.
- Latency: an address issued in cycle t appears on the bus in cycle t+1. Steady state with ds_allowin=1 is one instruction per cycle, PCs increasing by 4.
- Branch/cancel:
  - fs_to_ds_valid = fs_valid & ~br_taken. The instruction in IF during br_taken is wrong-path and is never delivered.
  - br_taken overrides a stall: the target fetch issues in the same cycle even if ds_allowin=0.
  - br_taken clears inst_buf_valid.
- Instruction buffer:
  - Fill: if fs_valid & ~ds_allowin & ~inst_buf_valid & ~br_taken, then inst_buf<=inst_sram_rdata and inst_buf_valid<=1.
  - Clear: on ds_allowin or br_taken.
  - While a stall persists, SRAM output is ignored.
- Bus fields:
  - inst = fs_adef ? 32'h0 : (inst_buf_valid ? inst_buf : inst_sram_rdata).
  - pc = fs_pc, adef = fs_adef.
- Misaligned target:
  - No SRAM access is made.
  - The stage still presents fs_valid=1 with adef=1, so ID can raise ADEF.
  - The following sequential fetch continues from target+4 unless redirected.
- Long stall: fs_pc, fs_valid and the bus hold constant for any number of ds_allowin=0 cycles.
- Reset mid-operation: pending fetch, buffer and cancel state are all discarded. The first post-reset fetch is RESET_PC.

Test Plan:
- Reset sequence: hold reset 3 cycles, then release with ds_allowin=1 → cycle 1 after release: en=1, addr=1c000000. Cycle 2: valid=1, pc=1c000000, inst equals memory word. Cycle 3: pc=1c000004.
- Stall with buffer: ds_allowin=0 for 4 cycles while pc=1c000008 is valid, and SRAM rdata is changed to 32'hdeadbeef → the bus holds pc=1c000008 and the original inst. After release, next pc=1c00000c.
- Redirect: br_taken=1 with br_target=1c000100 while pc=1c000010 is in IF → fs_to_ds_valid=0 that cycle, addr=1c000100. Next cycle: pc=1c000100, valid=1.
- Redirect during stall: ds_allowin=0 with the buffer full, then br_taken=1 with target 1c000200 → buffer cleared, en=1, addr=1c000200. The next delivered pc is 1c000200.
- Misaligned target: br_target=1c000102 → en=0 that cycle. Next cycle: valid=1, adef=1, inst=0, pc=1c000102. The following fetch address is 1c000106.
- Reset mid-stall: reset asserted with a buffered instruction → valid=0 and en=0 during reset. The first fetch after release is 1c000000 and the stale buffer is never output.
